datapath_arbiter: RTL and testbench
===================================

// Module: datapath_arbiter
// PURPOSE
//  Shares the single Datapath (register file, ALU, data memory) between two requesters:
//  the core Controller (port 0) and a debug/loader host (port 1). One operation at a time:
//  the winner's control bundle is latched and driven to the Datapath for OP_CYCLES cycles,
//  then read data is returned with a one-cycle ack. The core has priority; the host has a starvation bound.
// PARAMETERS
//  OP_CYCLES   2   cycles a latched op is held on the Datapath (>=1); covers memory read latency
//  STARVE_MAX  4   max consecutive core grants while host_req is pending (>=1)
//  DATA_W      16  Datapath data width
// PORTS
//  Clk         in   1       clock, rising edge
//  Reset       in   1       asynchronous, active-low reset
//  core_req    in   1       core requests an op; held until core_ack
//  core_op     in   dp_op_t core control bundle; stable while core_req is high
//  core_ack    out  1       one-cycle completion pulse to core
//  host_req    in   1       host requests an op; held until host_ack
//  host_op     in   dp_op_t host control bundle
//  host_ack    out  1       one-cycle completion pulse to host
//  dp_op       out  dp_op_t controls to Datapath {alu_s[2:0],rf_s,d_wr,d_addr[7:0],rf_w_addr[3:0],rf_w_en,rf_a[3:0],rf_b[3:0]}
//  dp_r_data   in   DATA_W  Datapath read data
//  rd_data     out  DATA_W  captured read data; valid when either ack is high
//  busy        out  1       high in EXEC and RESP
//  owner       out  1       0=core, 1=host; owner of the current or last op
// BEHAVIOUR
//  Reset: state=IDLE, core_ack=0, host_ack=0, rd_data=0, busy=0, owner=0, starve_cnt=0, dp_op=DP_NOP.
//  DP_NOP = all fields 0 (d_wr=0, rf_w_en=0). dp_op is decoded from state and is DP_NOP outside EXEC.
//  FSM IDLE -> EXEC -> RESP -> IDLE:
//   IDLE: if no req, stay. Otherwise pick the winner, latch its op into op_q, set owner,
//         load cyc_cnt=OP_CYCLES-1, and go to EXEC.
//   EXEC: dp_op=op_q with d_wr and rf_w_en forced to 0, except in the last EXEC cycle (cyc_cnt==0).
//         Write strobes are therefore single-cycle. In the last cycle, rd_data<=dp_r_data; go to RESP.
//   RESP: ack[owner]=1 for exactly 1 cycle; go to IDLE. Requests are not sampled in RESP.
//  Transaction time: grant edge to ack = OP_CYCLES+1 cycles; minimum request spacing = OP_CYCLES+2.
//  Arbitration (IDLE only):
//   - core wins if core_req && !(host_req && starve_cnt==STARVE_MAX); otherwise host wins if host_req.
//   - starve_cnt: +1 (saturating at STARVE_MAX) on a core grant while host_req=1.
//     Cleared on a host grant, or in IDLE when host_req=0.
//  Handshake: the op is sampled only at the grant edge. A request dropped before grant is withdrawn
//  with no effect. A request dropped after grant still completes, and ack still pulses.
//  Simultaneous requests with starve_cnt<STARVE_MAX: core wins and the host waits.
//  Reset mid-operation: asynchronous; dp_op returns to DP_NOP immediately. The in-flight op is
//  abandoned with no ack and no partial write beyond strobes already issued.
//  rd_data holds its value until the next capture. Widths pass through unchanged; no arithmetic.
// STRUCTURE
//  processor_pkg: typedef packed struct dp_op_t; localparam DP_NOP; typedef enum {IDLE,EXEC,RESP} arb_state_t.
//  Sub-module starve_arbiter: combinational pick, starve_cnt register, and owner output.
//  The FSM, cycle counter, op_q and rd_data stay in datapath_arbiter.
// TESTING
//  1 core_req alone, core_op.d_addr=8'h10, d_wr=0, dp_r_data=16'hBEEF -> dp_op=op for 2 cycles,
//    core_ack 3 cycles after grant, rd_data=16'hBEEF, owner=0.
//  2 host_req write, d_addr=8'h20, d_wr=1, OP_CYCLES=2 -> d_wr high only in the 2nd EXEC cycle;
//    host_ack pulses once; core_ack stays 0.
//  3 core_req and host_req held high continuously -> grant order C,C,C,C,H,C,C,C,C,H;
//    starve_cnt returns to 0 after each H.
//  4 host_req dropped the cycle before grant -> no host op, dp_op stays DP_NOP, no host_ack.
//  5 Reset driven low in the first EXEC cycle of a write -> dp_op=DP_NOP, d_wr never asserted,
//    no ack, all outputs at reset values.
//  6 OP_CYCLES=1, core read -> single EXEC cycle with strobes; ack 2 cycles after grant;
//    back-to-back requests spaced by 3 cycles.

Source files
------------

// File: rtl/datapath_arbiter_pkg.sv
// Shared types for the datapath arbiter: the Datapath control bundle, its idle value
// and the arbiter FSM states.
package datapath_arbiter_pkg;

  typedef struct packed {
    logic [2:0] alu_s;
    logic       rf_s;
    logic       d_wr;
    logic [7:0] d_addr;
    logic [3:0] rf_w_addr;
    logic       rf_w_en;
    logic [3:0] rf_a;
    logic [3:0] rf_b;
  } dp_op_t;

  localparam dp_op_t DP_NOP = '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  // Write strobes may only reach the Datapath in the final EXEC cycle.
  function automatic dp_op_t strip_strobes(dp_op_t op);
    dp_op_t res;
    res         = op;
    res.d_wr    = 1'b0;
    res.rf_w_en = 1'b0;
    return res;
  endfunction

  function automatic int cnt_width(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/datapath_arbiter_if.sv
// Bundle of requester handshakes and Datapath signals around the arbiter.
// master = requesters/Datapath side, slave = the arbiter itself.
interface datapath_arbiter_if #(
  parameter int DATA_W = 16
);
  import datapath_arbiter_pkg::*;

  logic              core_req;
  dp_op_t            core_op;
  logic              core_ack;
  logic              host_req;
  dp_op_t            host_op;
  logic              host_ack;
  dp_op_t            dp_op;
  logic [DATA_W-1:0] dp_r_data;
  logic [DATA_W-1:0] rd_data;
  logic              busy;
  logic              owner;

  modport master (
    output core_req, core_op, host_req, host_op, dp_r_data,
    input  core_ack, host_ack, dp_op, rd_data, busy, owner
  );

  modport slave (
    input  core_req, core_op, host_req, host_op, dp_r_data,
    output core_ack, host_ack, dp_op, rd_data, busy, owner
  );

endinterface

// File: rtl/datapath_arbiter_starve_arbiter.sv
// Core-priority pick with a host starvation bound; also remembers who owns the
// current (or last) Datapath operation.
module starve_arbiter
  import datapath_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic core_req_i,
  input  logic host_req_i,
  input  logic grant_en_i,
  output logic grant_o,
  output logic grant_host_o,
  output logic owner_o
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [SW-1:0] starve_cnt_q;
  logic [SW-1:0] starve_cnt_d;
  logic          owner_q;
  logic          owner_d;
  logic          starved;

  always_comb begin
    starved      = host_req_i && (starve_cnt_q == SW'(STARVE_MAX));
    grant_host_o = host_req_i && (starved || !core_req_i);
    grant_o      = grant_en_i && (core_req_i || host_req_i);

    starve_cnt_d = starve_cnt_q;
    owner_d      = owner_q;
    if (grant_en_i) begin
      // Remaining case is a core grant with the host waiting, so the count is below max.
      if (!host_req_i || grant_host_o) begin
        starve_cnt_d = '0;
      end else begin
        starve_cnt_d = starve_cnt_q + SW'(1);
      end
      if (grant_o) begin
        owner_d = grant_host_o;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
      owner_q      <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      owner_q      <= owner_d;
    end
  end

  assign owner_o = owner_q;

endmodule

// File: rtl/datapath_arbiter.sv
// Shares one Datapath between the core (port 0) and a debug host (port 1):
// latch the winner's op, hold it for OP_CYCLES, capture read data, pulse the ack.
module datapath_arbiter
  import datapath_arbiter_pkg::*;
#(
  parameter int OP_CYCLES  = 2,
  parameter int STARVE_MAX = 4,
  parameter int DATA_W     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  datapath_arbiter_if.slave  bus
);

  localparam int CW = cnt_width(OP_CYCLES);

  arb_state_t        state_q;
  logic [CW-1:0]     cyc_cnt_q;
  dp_op_t            op_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              core_ack_q;
  logic              host_ack_q;

  logic grant;
  logic grant_host;
  logic owner;
  logic last_cyc;

  starve_arbiter #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .clk          (clk),
    .rst_n        (rst_n),
    .core_req_i   (bus.core_req),
    .host_req_i   (bus.host_req),
    .grant_en_i   (state_q == IDLE),
    .grant_o      (grant),
    .grant_host_o (grant_host),
    .owner_o      (owner)
  );

  assign last_cyc = (cyc_cnt_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cyc_cnt_q  <= '0;
      op_q       <= DP_NOP;
      rd_data_q  <= '0;
      core_ack_q <= 1'b0;
      host_ack_q <= 1'b0;
    end else begin
      core_ack_q <= 1'b0;
      host_ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant) begin
            op_q      <= grant_host ? bus.host_op : bus.core_op;
            cyc_cnt_q <= CW'(OP_CYCLES - 1);
            state_q   <= EXEC;
          end
        end
        EXEC: begin
          if (last_cyc) begin
            // Owner was set at the grant edge, so it already names this op's requester.
            rd_data_q  <= bus.dp_r_data;
            core_ack_q <= !owner;
            host_ack_q <= owner;
            state_q    <= RESP;
          end else begin
            cyc_cnt_q <= cyc_cnt_q - CW'(1);
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Decoded from state so an asynchronous reset drops the Datapath to NOP at once.
  always_comb begin
    bus.dp_op = DP_NOP;
    if (state_q == EXEC) begin
      bus.dp_op = last_cyc ? op_q : strip_strobes(op_q);
    end
  end

  assign bus.core_ack = core_ack_q;
  assign bus.host_ack = host_ack_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.owner    = owner;

endmodule

// File: tb/tb_datapath_arbiter.sv
// Directed bench for datapath_arbiter: one instance with OP_CYCLES=2 and a registered
// memory model, one with OP_CYCLES=1 and a combinational memory; acks checked against a scoreboard.
`timescale 1ns/1ps
module tb_datapath_arbiter;
  import datapath_arbiter_pkg::*;

  typedef struct {
    logic        host;
    logic [15:0] rd;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  datapath_arbiter_if #(.DATA_W(16)) a_if ();
  datapath_arbiter_if #(.DATA_W(16)) b_if ();

  datapath_arbiter #(.OP_CYCLES(2), .STARVE_MAX(4), .DATA_W(16)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (a_if.slave)
  );

  datapath_arbiter #(.OP_CYCLES(1), .STARVE_MAX(4), .DATA_W(16)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b_if.slave)
  );

  logic [15:0] tb_mem [256];
  logic [15:0] a_rd_q;
  always @(posedge clk) a_rd_q <= tb_mem[a_if.dp_op.d_addr];
  assign a_if.dp_r_data = a_rd_q;
  assign b_if.dp_r_data = tb_mem[b_if.dp_op.d_addr];

  int   checks = 0;
  int   failures = 0;
  int   a_dwr_cnt = 0;
  exp_t q_a[$];
  exp_t q_b[$];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic dp_op_t mk_op(logic [7:0] addr, logic wr, logic [2:0] alu, logic [3:0] wa);
    dp_op_t o;
    o.alu_s     = alu;
    o.rf_s      = 1'b1;
    o.d_wr      = wr;
    o.d_addr    = addr;
    o.rf_w_addr = wa;
    o.rf_w_en   = 1'b1;
    o.rf_a      = 4'h5;
    o.rf_b      = 4'hA;
    return o;
  endfunction

  function automatic dp_op_t no_strobe(dp_op_t o);
    dp_op_t r;
    r         = o;
    r.d_wr    = 1'b0;
    r.rf_w_en = 1'b0;
    return r;
  endfunction

  always @(negedge clk) begin
    if (a_if.dp_op.d_wr) a_dwr_cnt++;
  end

  // Scoreboard: each ack pops the oldest expectation of its instance.
  always @(negedge clk) begin
    if (rst_n && (a_if.core_ack || a_if.host_ack)) begin
      if (q_a.size() == 0) begin
        chk("a_unexpected_ack", {30'd0, a_if.host_ack, a_if.core_ack}, 32'd0);
      end else begin
        exp_t e;
        e = q_a.pop_front();
        $display("A ack: host=%0d rd_data=%h (expect host=%0d rd=%h)", a_if.host_ack, a_if.rd_data, e.host, e.rd);
        chk("a_ack_port", {30'd0, a_if.host_ack, a_if.core_ack}, e.host ? 32'd2 : 32'd1);
        chk("a_owner", 32'(a_if.owner), 32'(e.host));
        chk("a_rd_data", 32'(a_if.rd_data), 32'(e.rd));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && (b_if.core_ack || b_if.host_ack)) begin
      if (q_b.size() == 0) begin
        chk("b_unexpected_ack", {30'd0, b_if.host_ack, b_if.core_ack}, 32'd0);
      end else begin
        exp_t e;
        e = q_b.pop_front();
        $display("B ack: host=%0d rd_data=%h (expect host=%0d rd=%h)", b_if.host_ack, b_if.rd_data, e.host, e.rd);
        chk("b_ack_port", {30'd0, b_if.host_ack, b_if.core_ack}, e.host ? 32'd2 : 32'd1);
        chk("b_rd_data", 32'(b_if.rd_data), 32'(e.rd));
      end
    end
  end

  initial begin
    dp_op_t op1, op2, opc, oph, opd, op5;
    dp_op_t ops6 [3];
    int     base, n, cyc, exp_starve;

    for (int i = 0; i < 256; i++) tb_mem[i] = {8'(i), ~8'(i)};
    tb_mem[0]     = 16'h0BAD;
    tb_mem[8'h10] = 16'hBEEF;

    a_if.core_req = 1'b0; a_if.core_op = DP_NOP; a_if.host_req = 1'b0; a_if.host_op = DP_NOP;
    b_if.core_req = 1'b0; b_if.core_op = DP_NOP; b_if.host_req = 1'b0; b_if.host_op = DP_NOP;

    // Reset values
    tick(); tick();
    chk("rst_dp_op", 32'(a_if.dp_op), 32'(DP_NOP));
    chk("rst_busy", 32'(a_if.busy), 32'd0);
    chk("rst_owner", 32'(a_if.owner), 32'd0);
    chk("rst_acks", {30'd0, a_if.host_ack, a_if.core_ack}, 32'd0);
    chk("rst_rd_data", 32'(a_if.rd_data), 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: core read, OP_CYCLES=2
    op1 = mk_op(8'h10, 1'b0, 3'd2, 4'h3);
    a_if.core_op = op1; a_if.core_req = 1'b1;
    q_a.push_back('{host: 1'b0, rd: 16'hBEEF});
    tick();
    chk("t1_exec1_dp_op", 32'(a_if.dp_op), 32'(no_strobe(op1)));
    chk("t1_busy", 32'(a_if.busy), 32'd1);
    tick();
    chk("t1_exec2_dp_op", 32'(a_if.dp_op), 32'(op1));
    chk("t1_no_early_ack", 32'(a_if.core_ack), 32'd0);
    tick();
    chk("t1_core_ack", 32'(a_if.core_ack), 32'd1);
    chk("t1_resp_nop", 32'(a_if.dp_op), 32'(DP_NOP));
    a_if.core_req = 1'b0;
    tick();
    chk("t1_idle_busy", 32'(a_if.busy), 32'd0);
    chk("t1_ack_cleared", 32'(a_if.core_ack), 32'd0);
    chk("t1_rd_hold", 32'(a_if.rd_data), 32'hBEEF);

    // 2: host write, strobe only in the last EXEC cycle, request dropped after grant
    base = a_dwr_cnt;
    op2 = mk_op(8'h20, 1'b1, 3'd5, 4'h7);
    a_if.host_op = op2; a_if.host_req = 1'b1;
    q_a.push_back('{host: 1'b1, rd: tb_mem[8'h20]});
    tick();
    chk("t2_exec1_dp_op", 32'(a_if.dp_op), 32'(no_strobe(op2)));
    chk("t2_owner", 32'(a_if.owner), 32'd1);
    a_if.host_req = 1'b0;
    tick();
    chk("t2_exec2_d_wr", 32'(a_if.dp_op.d_wr), 32'd1);
    chk("t2_exec2_dp_op", 32'(a_if.dp_op), 32'(op2));
    tick();
    chk("t2_host_ack", 32'(a_if.host_ack), 32'd1);
    chk("t2_core_ack_low", 32'(a_if.core_ack), 32'd0);
    tick();
    chk("t2_owner_hold", 32'(a_if.owner), 32'd1);
    chk("t2_dwr_pulses", 32'(a_dwr_cnt - base), 32'd1);

    // 3: both held continuously -> C,C,C,C,H repeating
    base = a_dwr_cnt;
    opc = mk_op(8'h30, 1'b0, 3'd1, 4'h1);
    oph = mk_op(8'h40, 1'b1, 3'd4, 4'h2);
    for (int i = 0; i < 10; i++)
      q_a.push_back('{host: (i % 5 == 4), rd: (i % 5 == 4) ? tb_mem[8'h40] : tb_mem[8'h30]});
    a_if.core_op = opc; a_if.host_op = oph;
    a_if.core_req = 1'b1; a_if.host_req = 1'b1;
    n = 0; cyc = 0;
    while (n < 10 && cyc < 200) begin
      tick();
      cyc++;
      if (a_if.core_ack || a_if.host_ack) begin
        exp_starve = (n % 5 == 4) ? 0 : (n % 5) + 1;
        chk("t3_starve_cnt", 32'(dut_a.u_starve.starve_cnt_q), 32'(exp_starve));
        n++;
        if (n == 10) begin
          a_if.core_req = 1'b0; a_if.host_req = 1'b0;
        end
      end
    end
    chk("t3_ack_count", 32'(n), 32'd10);
    tick(); tick();
    chk("t3_queue_drained", 32'(q_a.size()), 32'd0);
    chk("t3_idle", 32'(a_if.busy), 32'd0);
    chk("t3_dwr_pulses", 32'(a_dwr_cnt - base), 32'd2);

    // 4: host request withdrawn before it could be granted
    opd = mk_op(8'h50, 1'b0, 3'd3, 4'h4);
    a_if.core_op = opd; a_if.core_req = 1'b1;
    q_a.push_back('{host: 1'b0, rd: tb_mem[8'h50]});
    tick();
    a_if.core_req = 1'b0;
    a_if.host_op = oph; a_if.host_req = 1'b1;
    tick();
    tick();
    a_if.host_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_dp_nop", 32'(a_if.dp_op), 32'(DP_NOP));
      chk("t4_not_busy", 32'(a_if.busy), 32'd0);
    end
    chk("t4_owner_core", 32'(a_if.owner), 32'd0);
    chk("t4_queue_drained", 32'(q_a.size()), 32'd0);

    // 5: reset in the first EXEC cycle of a write
    base = a_dwr_cnt;
    op5 = mk_op(8'h60, 1'b1, 3'd6, 4'h6);
    a_if.host_op = op5; a_if.host_req = 1'b1;
    tick();
    chk("t5_exec1_no_wr", 32'(a_if.dp_op.d_wr), 32'd0);
    chk("t5_busy", 32'(a_if.busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_dp_nop", 32'(a_if.dp_op), 32'(DP_NOP));
    chk("t5_busy_rst", 32'(a_if.busy), 32'd0);
    chk("t5_owner_rst", 32'(a_if.owner), 32'd0);
    chk("t5_rd_rst", 32'(a_if.rd_data), 32'd0);
    chk("t5_starve_rst", 32'(dut_a.u_starve.starve_cnt_q), 32'd0);
    a_if.host_req = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick(); tick();
    chk("t5_no_dwr", 32'(a_dwr_cnt - base), 32'd0);
    chk("t5_acks_low", {30'd0, a_if.host_ack, a_if.core_ack}, 32'd0);
    chk("t5_idle", 32'(a_if.busy), 32'd0);

    // 6: OP_CYCLES=1, back-to-back core reads every 3 cycles
    for (int i = 0; i < 3; i++) begin
      ops6[i] = mk_op(8'h10 + 8'(i), 1'b0, 3'(i), 4'(i + 8));
      q_b.push_back('{host: 1'b0, rd: tb_mem[8'h10 + 8'(i)]});
    end
    b_if.core_op = ops6[0]; b_if.core_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_exec_dp_op", 32'(b_if.dp_op), 32'(ops6[i]));
      chk("t6_exec_no_ack", 32'(b_if.core_ack), 32'd0);
      tick();
      chk("t6_core_ack", 32'(b_if.core_ack), 32'd1);
      chk("t6_resp_nop", 32'(b_if.dp_op), 32'(DP_NOP));
      if (i < 2) b_if.core_op = ops6[i + 1];
      else       b_if.core_req = 1'b0;
      tick();
      chk("t6_idle", 32'(b_if.busy), 32'd0);
    end
    tick();
    chk("t6_queue_drained", 32'(q_b.size()), 32'd0);
    chk("t6_rd_hold", 32'(b_if.rd_data), 32'(tb_mem[8'h12]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
